// File: rtl/huff_pkg.sv
// Huffman code table shared by the serial encoder and the matching decoder.
// Codes are right-aligned; a length of zero marks a symbol with no code.
package huff_pkg;

  localparam int MAX_LEN = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } enc_state_t;

  // Index is the symbol: {7,6,5,4,3,2,1,0}
  localparam logic [7:0][3:0] HUFF_CODE = {4'h0, 4'hC, 4'hD, 4'h7, 4'h4, 4'h5, 4'h0, 4'h0};
  localparam logic [7:0][2:0] HUFF_LEN  = {3'd0, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd1, 3'd0};

endpackage

// File: rtl/huff_code_rom.sv
// Combinational symbol-to-code lookup built from the shared table.
module huff_code_rom
  import huff_pkg::*;
(
  input  logic [2:0] sym,
  output logic [3:0] code,
  output logic [2:0] len,
  output logic       legal
);

  assign code  = HUFF_CODE[sym];
  assign len   = HUFF_LEN[sym];
  assign legal = (HUFF_LEN[sym] != 3'd0);

endmodule

// File: rtl/huffman_encoder.sv
// Serialising Huffman encoder: takes 3-bit symbols over valid/ready and shifts
// the prefix code out MSB-first at one bit per clock with no gaps between codes.
module huffman_encoder
  import huff_pkg::*;
#(
  parameter logic IDLE_X = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       x,
  output logic       x_valid,
  output logic       err
);

  logic [3:0] code;
  logic [2:0] len;
  logic       legal;
  logic [3:0] aligned;

  logic [2:0] sr, sr_n;
  logic [1:0] cnt, cnt_n;
  logic       x_n, x_valid_n, err_n;
  enc_state_t state;

  huff_code_rom u_rom (
    .sym   (sym_in),
    .code  (code),
    .len   (len),
    .legal (legal)
  );

  // Left-align the code so its first bit lands in aligned[3]
  assign aligned   = code << (3'(MAX_LEN) - len);
  assign state     = (cnt == 2'd0) ? IDLE : SHIFT;
  assign sym_ready = (state == IDLE);

  always_comb begin
    x_n       = x;
    x_valid_n = x_valid;
    err_n     = 1'b0;
    sr_n      = sr;
    cnt_n     = cnt;
    case (state)
      SHIFT: begin
        x_n       = sr[2];
        sr_n      = {sr[1:0], 1'b0};
        cnt_n     = cnt - 2'd1;
        x_valid_n = 1'b1;
      end
      default: begin
        if (sym_valid && legal) begin
          x_n       = aligned[3];
          sr_n      = aligned[2:0];
          cnt_n     = 2'(len - 3'd1);
          x_valid_n = 1'b1;
        end else begin
          // Illegal symbols are consumed and flagged but emit nothing
          err_n     = sym_valid;
          x_n       = IDLE_X;
          x_valid_n = 1'b0;
          sr_n      = 3'd0;
          cnt_n     = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= IDLE_X;
      x_valid <= 1'b0;
      err     <= 1'b0;
      sr      <= 3'd0;
      cnt     <= 2'd0;
    end else begin
      x       <= x_n;
      x_valid <= x_valid_n;
      err     <= err_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder: streaming, illegal symbols,
// back-pressure, reset mid-code and idle behaviour.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       x;
  logic       x_valid;
  logic       err;

  int checks = 0;
  int errors = 0;

  huffman_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .x         (x),
    .x_valid   (x_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent hand-written code table: first element of the string is the first bit sent
  function automatic string exp_code(input logic [2:0] s);
    case (s)
      3'd1:    return "0";
      3'd3:    return "100";
      3'd2:    return "101";
      3'd4:    return "111";
      3'd6:    return "1100";
      3'd5:    return "1101";
      default: return "";
    endcase
  endfunction

  // Present a symbol, then check every emitted bit; during the shift the input
  // switches to next_sym to show it is ignored until ready returns
  task automatic apply_stimulus(input logic [2:0] s, input logic [2:0] next_sym);
    string c;
    c = exp_code(s);
    check_output($sformatf("ready_before_%0d", s), 8'(sym_ready), 8'd1);
    sym_in    = s;
    sym_valid = 1'b1;
    for (int i = 0; i < c.len(); i++) begin
      tick();
      sym_in = next_sym;
      check_output($sformatf("sym%0d_bit%0d_x", s, i), 8'(x), 8'(c[i] == "1"));
      check_output($sformatf("sym%0d_bit%0d_xv", s, i), 8'(x_valid), 8'd1);
      check_output($sformatf("sym%0d_bit%0d_err", s, i), 8'(err), 8'd0);
      check_output($sformatf("sym%0d_bit%0d_ready", s, i), 8'(sym_ready), 8'(i == c.len() - 1));
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_x"}, 8'(x), 8'd0);
    check_output({tag, "_xv"}, 8'(x_valid), 8'd0);
    check_output({tag, "_err"}, 8'(err), 8'd0);
    check_output({tag, "_ready"}, 8'(sym_ready), 8'd1);
  endtask

  initial begin
    reset     = 1'b1;
    sym_in    = 3'd0;
    sym_valid = 1'b0;
    #1;
    check_idle("reset");
    tick();
    reset = 1'b0;

    $display("[TB] gapless stream 1,3,2,4,6,5");
    apply_stimulus(3'd1, 3'd3);
    apply_stimulus(3'd3, 3'd2);
    apply_stimulus(3'd2, 3'd4);
    apply_stimulus(3'd4, 3'd6);
    apply_stimulus(3'd6, 3'd5);
    apply_stimulus(3'd5, 3'd5);
    sym_valid = 1'b0;
    tick();
    check_idle("after_stream1");

    $display("[TB] gapless stream 5,1,6,3");
    apply_stimulus(3'd5, 3'd1);
    apply_stimulus(3'd1, 3'd6);
    apply_stimulus(3'd6, 3'd3);
    apply_stimulus(3'd3, 3'd3);
    sym_valid = 1'b0;
    tick();
    check_idle("after_stream2");

    $display("[TB] illegal symbols");
    sym_in    = 3'd7;
    sym_valid = 1'b1;
    tick();
    check_output("sym7_err", 8'(err), 8'd1);
    check_output("sym7_xv", 8'(x_valid), 8'd0);
    check_output("sym7_x", 8'(x), 8'd0);
    check_output("sym7_ready", 8'(sym_ready), 8'd1);
    sym_in = 3'd0;
    tick();
    check_output("sym0_err", 8'(err), 8'd1);
    check_output("sym0_xv", 8'(x_valid), 8'd0);
    check_output("sym0_x", 8'(x), 8'd0);
    check_output("sym0_ready", 8'(sym_ready), 8'd1);
    apply_stimulus(3'd4, 3'd4);
    sym_valid = 1'b0;
    tick();
    check_idle("after_illegal");

    $display("[TB] held symbol during back-pressure");
    apply_stimulus(3'd6, 3'd2);
    apply_stimulus(3'd2, 3'd2);
    sym_valid = 1'b0;
    tick();
    check_idle("after_hold");

    $display("[TB] reset mid-code");
    sym_in    = 3'd5;
    sym_valid = 1'b1;
    tick();
    check_output("rst_bit0_x", 8'(x), 8'd1);
    sym_valid = 1'b0;
    tick();
    check_output("rst_bit1_x", 8'(x), 8'd1);
    check_output("rst_bit1_ready", 8'(sym_ready), 8'd0);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    tick();
    check_idle("held_reset");
    reset = 1'b0;
    tick();
    check_idle("after_release");
    apply_stimulus(3'd1, 3'd1);
    sym_valid = 1'b0;

    $display("[TB] idle for 10 cycles");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle($sformatf("idle%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
